// File: rtl/cadr_pkg.sv
// Constants shared by the CADR multiply/divide sequencer.
// Holds ALU function codes, the sequencer state encoding and the step count.
package cadr_pkg;

  localparam logic [3:0] ALUF_ADD   = 4'b1001;
  localparam logic [3:0] ALUF_SUB   = 4'b0110;
  localparam logic [3:0] ALUF_PASSB = 4'b1010;

  localparam int unsigned MD_STEPS = 32;
  localparam logic [5:0]  MD_LAST  = 6'(MD_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/mdstep_seq.sv
// Multiply/divide step sequencer: drives the external ALU one pass per clock
// and folds the returned result into the acc/q shift pair for 32 steps.
module mdstep_seq
  import cadr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_m,
  output logic [3:0]  aluf,
  output logic        alumode,
  output logic        cin0,
  input  logic [32:0] alu
);

  md_state_t   state, state_nxt;
  logic [31:0] acc, q, opr;
  logic [5:0]  cnt;
  logic        mode;

  logic        reject;
  logic        c32;
  logic        qbit;
  logic [31:0] shifted;

  // A divide by zero or by a divisor with bit 31 set is refused up front.
  assign reject  = op && ((opb == 32'd0) || opb[31]);
  assign shifted = {acc[30:0], q[31]};
  assign c32     = q[0] & ((opr[31] & acc[31]) | ((opr[31] | acc[31]) & ~alu[31]));
  assign qbit    = acc[31] | ~alu[32];

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign res_hi = acc;
  assign res_lo = q;

  always_comb begin
    state_nxt = state;
    alu_a     = acc;
    alu_m     = opr;
    aluf      = ALUF_PASSB;
    alumode   = 1'b1;
    cin0      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = reject ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        if (cnt == MD_LAST) state_nxt = ST_DONE;
        if (mode) begin
          alu_m   = shifted;
          alu_a   = opr;
          aluf    = ALUF_SUB;
          alumode = 1'b0;
          cin0    = 1'b1;
        end else if (q[0]) begin
          aluf    = ALUF_ADD;
          alumode = 1'b0;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Results and err persist through DONE and IDLE until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      q     <= '0;
      opr   <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            opr  <= opb;
            q    <= opa;
            acc  <= '0;
            cnt  <= '0;
            mode <= op;
            err  <= reject;
          end
        end
        ST_STEP: begin
          cnt <= cnt + 6'd1;
          if (mode) begin
            acc <= qbit ? alu[31:0] : shifted;
            q   <= {q[30:0], qbit};
          end else begin
            acc <= {c32, alu[31:1]};
            q   <= {alu[0], q[31:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdstep_seq.sv
// Bench for mdstep_seq with a behavioural ALU closing the loop; results are
// scored against a queue of expectations pushed when each request is issued.
module tb_mdstep_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] opa, opb;
  logic        busy, done, err;
  logic [31:0] res_hi, res_lo;
  logic [31:0] alu_a, alu_m;
  logic [3:0]  aluf;
  logic        alumode, cin0;
  logic [32:0] alu;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        e;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        e;
  } vec_t;
  vec_t vecs[8];

  mdstep_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .err(err), .res_hi(res_hi), .res_lo(res_lo),
    .alu_a(alu_a), .alu_m(alu_m), .aluf(aluf), .alumode(alumode), .cin0(cin0),
    .alu(alu)
  );

  always #5 clk = ~clk;

  // ALU stand-in: M port is the A operand, a port is B; bit 32 is the borrow/carry.
  always_comb begin
    alu = '0;
    if (alumode) begin
      if (aluf == 4'b1010) alu = {1'b0, alu_a};
    end else begin
      case (aluf)
        4'b1001: alu = {1'b0, alu_m} + {1'b0, alu_a} + 33'(cin0);
        4'b0110: alu = {1'b0, alu_m} - {1'b0, alu_a} - 33'd1 + 33'(cin0);
        default: alu = '0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      check("latency", 32'(lat), 32'(e.lat));
      check("res_hi", res_hi, e.hi);
      check("res_lo", res_lo, e.lo);
      check("err", 32'(err), 32'(e.e));
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
      check("err_hold", 32'(err), 32'(e.e));
      check("res_lo_hold", res_lo, e.lo);
    end
  endtask

  // Called at a negedge with the sequencer idle; poke_at>0 pulses a stray start then.
  task automatic apply_stimulus(input logic o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ehi, input logic [31:0] elo,
                                input logic ee, input int poke_at);
    exp_t e;
    int lat;
    e.hi = ehi; e.lo = elo; e.e = ee; e.lat = ee ? 1 : 33;
    sb.push_back(e);
    start = 1'b1; op = o; opa = a; opb = b;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (done) break;
      if (lat > 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL timeout: got no done after %0d cycles, expected done", lat);
        break;
      end
      if (lat == poke_at) begin
        start = 1'b1; op = 1'b1; opa = 32'd5; opb = 32'd0;
      end
    end
    check_output(lat);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        o;
    logic [63:0] p;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h00000002, 1'b0};
    vecs[3] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4] = '{1'b1, 32'd5,        32'd0,        32'd0,        32'd5,        1'b1};
    vecs[5] = '{1'b0, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0};
    vecs[6] = '{1'b1, 32'd9,        32'h80000000, 32'd0,        32'd9,        1'b1};
    vecs[7] = '{1'b1, 32'd6,        32'd7,        32'd6,        32'd0,        1'b0};

    reset = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res_hi", res_hi, 32'd0);
    check("rst_res_lo", res_lo, 32'd0);
    check("rst_aluf", 32'(aluf), 32'h0000000A);
    check("rst_alumode", 32'(alumode), 32'd1);
    check("rst_cin0", 32'(cin0), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      apply_stimulus(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].e, -1);

    $display("[TB] stray start during STEP");
    apply_stimulus(1'b0, 32'd100, 32'd200, 32'd0, 32'd20000, 1'b0, 5);

    $display("[TB] reset at step 10");
    start = 1'b1; op = 1'b0; opa = 32'hDEADBEEF; opb = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_hi", res_hi, 32'd0);
    check("mid_rst_lo", res_lo, 32'd0);
    reset = 1'b0;
    apply_stimulus(1'b1, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0, -1);

    for (int i = 0; i < 150; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (o) begin
        b = (b & 32'h7FFFFFFF) >> $urandom_range(0, 31);
        if (b == 32'd0) b = 32'd1;
        apply_stimulus(o, a, b, a % b, a / b, 1'b0, -1);
      end else begin
        p = 64'(a) * 64'(b);
        apply_stimulus(o, a, b, p[63:32], p[31:0], 1'b0, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
